pipeline_stall_sink: RTL and testbench
======================================

# pipeline_stall_sink

Terminal consumer for the stall-aware pipeline chain. It accepts words from the last pipeline stage's data/valid/flush outputs and drives the stall input of that stage. Words are buffered in a small first-word-fall-through FIFO drained by a ready/valid reader. Statistics counters let benches and software check delivery without loss, duplication or reordering across stalls and flushes.

## Interface
- DATA_W, 32, word width (matches the pipeline data path)
- DEPTH, 4, FIFO entries; power of two, at least 2
- CNT_W, 16, width of word_count

- clk  input  1  single clock, rising edge
- reset  input  1  synchronous, active-low reset (asserted when 0, sampled on rising clk)
- in_data  input  DATA_W  word from the upstream stage's outputs
- in_valid  input  1  upstream out_valid
- in_flush  input  1  upstream out_flush (one-cycle registered pulse)
- out_stall  output  1  to the upstream in_stall; 1 = word not accepted, hold it
- rd_data  output  DATA_W  head of FIFO
- rd_valid  output  1  FIFO non-empty
- rd_ready  input  1  reader pops the head when rd_valid & rd_ready
- word_count  output  CNT_W  total accepted words, wraps modulo 2^CNT_W
- flush_count  output  8  flush pulses seen, saturates at 255
- checksum  output  DATA_W  sum of accepted words modulo 2^DATA_W

## Operation
- accept = in_valid & !out_stall & !in_flush; push in_data at the tail.
- pop = rd_valid & rd_ready & !in_flush; advance the head.
- out_stall = (count == DEPTH). It is derived only from registered state: no combinational path from in_valid, in_flush or rd_ready.
- When full, out_stall stays 1 even in a cycle with a pop. Space freed by a pop is offered on the next cycle.
- Push and pop in the same cycle (0 < count < DEPTH): count unchanged; both pointers advance; data order preserved.
- Pointers wrap modulo DEPTH; count ranges 0..DEPTH.
- On accept: word_count += 1 (wraps); checksum += in_data (carry discarded).
- Flush (in_flush = 1):
  - read pointer, write pointer and count go to 0;
  - in_valid, in_data and rd_ready are ignored that cycle;
  - flush_count += 1, saturating at 255;
  - word_count and checksum are cumulative and NOT cleared.
- rd_data is the memory entry at the read pointer (first-word fall-through). It is don't-care when rd_valid = 0, but must not be X after reset; memory is not required to reset.
- Reset (reset = 0 at a clock edge), valid at any time including mid-stream or during a flush:
  - pointers and count = 0;
  - out_stall = 0, rd_valid = 0, rd_data = 0;
  - word_count = 0, flush_count = 0, checksum = 0;
  - overrides flush, accept and pop.

## Timing
- Word accepted at edge N into an empty FIFO: rd_valid = 1 and rd_data = that word from edge N onward (one-cycle latency).
- DEPTH-th outstanding accept at edge N: out_stall = 1 after edge N. The upstream stage holds its valid word, so no data is lost.
- First pop from full at edge N: out_stall = 0 after edge N; the held upstream word is accepted at edge N+1 at the earliest.
- Flush at edge N: rd_valid = 0 and out_stall = 0 after edge N; flush_count is updated after edge N.
- Counters and checksum update at the edge of the accepting cycle and are visible the following cycle.
- Sustained throughput: one word per cycle when rd_ready = 1 continuously and the FIFO never fills.

## Test plan
- Reset: drive reset = 0 for 3 cycles with in_valid = 1 and in_flush = 1 -> every output is 0 and rd_data is not X; release -> still idle.
- Stream 0x11, 0x22, 0x33 on consecutive cycles with rd_ready = 1 -> rd_data shows 0x11, 0x22, 0x33 one cycle after each accept; word_count = 3; checksum = 0x66; out_stall never 1.
- rd_ready = 0, offer 5 words 1..5 (DEPTH = 4) -> out_stall = 1 after the 4th accept; word 5 is held with word_count = 4. Pulse rd_ready once -> pops 1, out_stall drops, 5 accepted the next cycle; full drain yields 2, 3, 4, 5; checksum = 15.
- count = 2, push and pop together for 10 cycles -> count stays 2 and order is preserved; wrap-around is exercised (pointers pass DEPTH twice).
- Flush with 3 entries queued and in_valid = 1 (data 0xAA) plus rd_ready = 1 in the same cycle -> rd_valid = 0 next cycle; 0xAA not stored; flush_count = 1; word_count unchanged. 256 further flushes -> flush_count = 255.
- Reset asserted while full and stalled -> next cycle out_stall = 0, rd_valid = 0, all counters 0; a new word 0x5A after release appears on rd_data one cycle later.

Source files
------------

// File: rtl/pipeline_stall_sink.sv
// rtl/pipeline_stall_sink.sv - terminal pipeline consumer: FWFT FIFO, registered stall, delivery statistics
module pipeline_stall_sink #(
    parameter int DATA_W = 32,
    parameter int DEPTH  = 4,
    parameter int CNT_W  = 16
) (
    input  logic              clk,
    input  logic              reset,
    input  logic [DATA_W-1:0] in_data,
    input  logic              in_valid,
    input  logic              in_flush,
    output logic              out_stall,
    output logic [DATA_W-1:0] rd_data,
    output logic              rd_valid,
    input  logic              rd_ready,
    output logic [CNT_W-1:0]  word_count,
    output logic [7:0]        flush_count,
    output logic [DATA_W-1:0] checksum
);

    localparam int AW = $clog2(DEPTH);
    localparam int CW = $clog2(DEPTH + 1);

    logic [DATA_W-1:0] mem_q [DEPTH];
    logic [AW-1:0]     wptr_q, wptr_d;
    logic [AW-1:0]     rptr_q, rptr_d;
    logic [CW-1:0]     count_q, count_d;
    logic [CNT_W-1:0]  word_count_q, word_count_d;
    logic [7:0]        flush_count_q, flush_count_d;
    logic [DATA_W-1:0] checksum_q, checksum_d;
    logic              full;
    logic              accept;
    logic              pop;

    // Stall depends only on registered occupancy, so a pop never frees space in the same cycle.
    assign full      = (count_q == CW'(DEPTH));
    assign out_stall = full;
    assign rd_valid  = (count_q != '0);
    assign accept    = in_valid & ~full & ~in_flush;
    assign pop       = rd_valid & rd_ready & ~in_flush;

    // Masking keeps rd_data clean while the unreset memory is still unwritten.
    assign rd_data     = rd_valid ? mem_q[rptr_q] : '0;
    assign word_count  = word_count_q;
    assign flush_count = flush_count_q;
    assign checksum    = checksum_q;

    always_comb begin
        wptr_d        = wptr_q;
        rptr_d        = rptr_q;
        count_d       = count_q;
        word_count_d  = word_count_q;
        flush_count_d = flush_count_q;
        checksum_d    = checksum_q;
        if (in_flush) begin
            wptr_d  = '0;
            rptr_d  = '0;
            count_d = '0;
            if (flush_count_q != 8'hFF) begin
                flush_count_d = flush_count_q + 8'd1;
            end
        end else begin
            if (accept) begin
                wptr_d       = wptr_q + AW'(1);
                word_count_d = word_count_q + CNT_W'(1);
                checksum_d   = checksum_q + in_data;
            end
            if (pop) begin
                rptr_d = rptr_q + AW'(1);
            end
            case ({accept, pop})
                2'b10:   count_d = count_q + CW'(1);
                2'b01:   count_d = count_q - CW'(1);
                default: count_d = count_q;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            wptr_q        <= '0;
            rptr_q        <= '0;
            count_q       <= '0;
            word_count_q  <= '0;
            flush_count_q <= '0;
            checksum_q    <= '0;
        end else begin
            wptr_q        <= wptr_d;
            rptr_q        <= rptr_d;
            count_q       <= count_d;
            word_count_q  <= word_count_d;
            flush_count_q <= flush_count_d;
            checksum_q    <= checksum_d;
        end
    end

    always_ff @(posedge clk) begin
        if (reset && accept) begin
            mem_q[wptr_q] <= in_data;
        end
    end

endmodule

// File: tb/tb_pipeline_stall_sink.sv
// tb/tb_pipeline_stall_sink.sv - directed self-checking bench for pipeline_stall_sink
module tb_pipeline_stall_sink;

    logic        clk = 1'b0;
    logic        reset;
    logic [31:0] in_data;
    logic        in_valid;
    logic        in_flush;
    logic        out_stall;
    logic [31:0] rd_data;
    logic        rd_valid;
    logic        rd_ready;
    logic [15:0] word_count;
    logic [7:0]  flush_count;
    logic [31:0] checksum;

    int n_checks = 0;
    int n_passed = 0;

    pipeline_stall_sink #(.DATA_W(32), .DEPTH(4), .CNT_W(16)) dut (
        .clk         (clk),
        .reset       (reset),
        .in_data     (in_data),
        .in_valid    (in_valid),
        .in_flush    (in_flush),
        .out_stall   (out_stall),
        .rd_data     (rd_data),
        .rd_valid    (rd_valid),
        .rd_ready    (rd_ready),
        .word_count  (word_count),
        .flush_count (flush_count),
        .checksum    (checksum)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_checks++;
        if (obs !== exp) begin
            $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end else begin
            n_passed++;
        end
    endtask

    // One clock edge; outputs are sampled 1 ns after it.
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        reset    = 1'b0;
        in_valid = 1'b0;
        in_flush = 1'b0;
        rd_ready = 1'b0;
        step();
        reset = 1'b1;
    endtask

    initial begin
        reset    = 1'b0;
        in_valid = 1'b1;
        in_flush = 1'b1;
        in_data  = 32'hDEAD;
        rd_ready = 1'b1;
        repeat (3) step();
        chk("rst_stall",   out_stall,   0);
        chk("rst_valid",   rd_valid,    0);
        chk("rst_data",    rd_data,     0);
        chk("rst_wcnt",    word_count,  0);
        chk("rst_fcnt",    flush_count, 0);
        chk("rst_csum",    checksum,    0);
        reset    = 1'b1;
        in_valid = 1'b0;
        in_flush = 1'b0;
        step();
        chk("idle_valid",  rd_valid,    0);
        chk("idle_wcnt",   word_count,  0);
        chk("idle_fcnt",   flush_count, 0);

        // streaming with a ready reader
        rd_ready = 1'b1;
        in_valid = 1'b1;
        for (int i = 1; i <= 3; i++) begin
            in_data = 32'h11 * i;
            step();
            chk("strm_data",  rd_data,   32'h11 * i);
            chk("strm_valid", rd_valid,  1);
            chk("strm_stall", out_stall, 0);
        end
        in_valid = 1'b0;
        step();
        chk("strm_empty", rd_valid,   0);
        chk("strm_wcnt",  word_count, 3);
        chk("strm_csum",  checksum,   32'h66);

        // fill to full, hold word 5, single pop, drain
        do_reset();
        in_valid = 1'b1;
        for (int i = 1; i <= 4; i++) begin
            in_data = i;
            step();
            chk("fill_stall", out_stall, (i == 4) ? 1 : 0);
        end
        in_data = 5;
        step();
        chk("held_stall", out_stall,  1);
        chk("held_wcnt",  word_count, 4);
        chk("held_head",  rd_data,    1);
        rd_ready = 1'b1;
        step();
        chk("pop1_stall", out_stall,  0);
        chk("pop1_head",  rd_data,    2);
        chk("pop1_wcnt",  word_count, 4);
        rd_ready = 1'b0;
        step();
        chk("acc5_wcnt",  word_count, 5);
        chk("acc5_stall", out_stall,  1);
        in_valid = 1'b0;
        rd_ready = 1'b1;
        for (int i = 3; i <= 5; i++) begin
            step();
            chk("drain_data", rd_data, i);
        end
        step();
        chk("drain_empty", rd_valid, 0);
        chk("drain_csum",  checksum, 15);

        // steady push+pop at count 2 across pointer wrap
        do_reset();
        in_valid = 1'b1;
        for (int i = 0; i < 2; i++) begin
            in_data = 32'h100 + i;
            step();
        end
        chk("ss_head0", rd_data, 32'h100);
        rd_ready = 1'b1;
        for (int i = 0; i < 10; i++) begin
            in_data = 32'h102 + i;
            step();
            chk("ss_head",  rd_data,   32'h101 + i);
            chk("ss_stall", out_stall, 0);
        end
        in_valid = 1'b0;
        step();
        chk("ss_tail",  rd_data,    32'h10B);
        chk("ss_valid", rd_valid,   1);
        step();
        chk("ss_empty", rd_valid,   0);
        chk("ss_wcnt",  word_count, 12);

        // flush with data and reader active in the same cycle
        do_reset();
        in_valid = 1'b1;
        for (int i = 1; i <= 3; i++) begin
            in_data = i;
            step();
        end
        in_data  = 32'hAA;
        rd_ready = 1'b1;
        in_flush = 1'b1;
        step();
        chk("fl_valid", rd_valid,    0);
        chk("fl_stall", out_stall,   0);
        chk("fl_fcnt",  flush_count, 1);
        chk("fl_wcnt",  word_count,  3);
        chk("fl_csum",  checksum,    6);
        in_flush = 1'b0;
        in_valid = 1'b0;
        step();
        chk("fl_noaa",  rd_valid,    0);
        in_flush = 1'b1;
        repeat (256) step();
        chk("fl_sat",   flush_count, 255);
        in_flush = 1'b0;

        // reset while full and stalled
        rd_ready = 1'b0;
        in_valid = 1'b1;
        for (int i = 1; i <= 5; i++) begin
            in_data = 32'h40 + i;
            step();
        end
        chk("rf_stall", out_stall, 1);
        reset = 1'b0;
        step();
        chk("rf_stall0", out_stall,   0);
        chk("rf_valid0", rd_valid,    0);
        chk("rf_wcnt0",  word_count,  0);
        chk("rf_fcnt0",  flush_count, 0);
        chk("rf_csum0",  checksum,    0);
        reset   = 1'b1;
        in_data = 32'h5A;
        step();
        in_valid = 1'b0;
        chk("rf_data",  rd_data,    32'h5A);
        chk("rf_valid", rd_valid,   1);
        chk("rf_wcnt",  word_count, 1);
        chk("rf_csum",  checksum,   32'h5A);

        $display("%0d/%0d checks passed", n_passed, n_checks);
        $finish;
    end

endmodule
